// File: rtl/ls_xing_pkg.sv
// Shared types and limits for the level-shifter receive stage (ls_xing_rx).
package ls_xing_pkg;

    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 4;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        IDLE  = 2'd1,
        VALID = 2'd2,
        ACK   = 2'd3
    } ls_xing_state_e;

endpackage

// File: rtl/ls_xing_rx_if.sv
// Bus bundle for ls_xing_rx: the 4-phase req/ack source side and the valid/ready consumer side.
// Valid/ready: a word moves on every clk edge where out_valid=1 and out_ready=1; out_valid and
// out_data hold until that edge, and out_valid may only fall without it when the source powers off.
interface ls_xing_rx_if #(
    parameter int DATA_W = 8
);
    logic              ls_req;
    logic [DATA_W-1:0] ls_data;
    logic              ls_ack;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output ls_req, ls_data, out_ready,
        input  ls_ack, out_valid, out_data
    );

    modport slave (
        input  ls_req, ls_data, out_ready,
        output ls_ack, out_valid, out_data
    );
endinterface

// File: rtl/lp_sync_cell.sv
// Single-bit N-stage synchroniser with asynchronous active-low clear.
module lp_sync_cell #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/ls_xing_rx.sv
// High-domain receiver for the level-shifted 4-phase bus; drops traffic cleanly on source power-off.
// Optional build macro LS_XING_PARITY_EN adds ls_parity (even parity) and a parity_err pulse.
module ls_xing_rx
    import ls_xing_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    ls_xing_rx_if.slave         bus,
    input  logic                src_pwr_ok,
`ifdef LS_XING_PARITY_EN
    input  logic                ls_parity,
    output logic                parity_err,
`endif
    output logic                busy,
    output logic [CNT_W-1:0]    drop_cnt,
    output ls_xing_state_e      state_dbg
);

    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
        $error("ls_xing_rx: SYNC_STAGES out of range");
    end

    logic req_s;
    logic pok_s;

    lp_sync_cell #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.ls_req),
        .q     (req_s)
    );

    lp_sync_cell #(.STAGES(SYNC_STAGES)) u_pok_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (src_pwr_ok),
        .q     (pok_s)
    );

    ls_xing_state_e    state;
    ls_xing_state_e    next_state;
    logic              capture;
    logic              drop;
    logic              par_bad;
    logic              ack_q;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    // ls_data is only looked at once req_s has settled high, so it needs no synchroniser.
`ifdef LS_XING_PARITY_EN
    assign par_bad = ((^bus.ls_data) != ls_parity);
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        next_state = state;
        capture    = 1'b0;
        drop       = 1'b0;
        if (!pok_s) begin
            next_state = OFF;
            drop       = (state == VALID);
        end else begin
            case (state)
                OFF:     if (!req_s) next_state = IDLE;
                IDLE: begin
                    if (req_s) begin
                        capture    = 1'b1;
                        next_state = par_bad ? ACK : VALID;
                    end
                end
                VALID:   if (bus.out_ready) next_state = ACK;
                ACK:     if (!req_s) next_state = IDLE;
                default: next_state = OFF;
            endcase
        end
    end

    // Outputs are registered from next_state so ls_ack leaves on a clean flop edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= OFF;
            ack_q    <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            drop_cnt <= '0;
        end else begin
            state   <= next_state;
            ack_q   <= (next_state == ACK);
            valid_q <= (next_state == VALID);
            if (capture) begin
                data_q <= bus.ls_data;
            end
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

`ifdef LS_XING_PARITY_EN
    logic perr_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= capture && par_bad;
        end
    end
    assign parity_err = perr_q;
`endif

    assign bus.ls_ack    = ack_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign busy          = (state == VALID) || (state == ACK);
    assign state_dbg     = state;

endmodule

// File: tb/tb_ls_xing_rx.sv
// Directed self-checking bench for ls_xing_rx (SYNC_STAGES=2, CNT_W=2 to reach saturation quickly).
module tb_ls_xing_rx;
    import ls_xing_pkg::*;

    logic           clk;
    logic           rst_n;
    logic           src_pwr_ok;
    logic           busy;
    logic [1:0]     drop_cnt;
    ls_xing_state_e state_dbg;
`ifdef LS_XING_PARITY_EN
    logic           ls_parity;
    logic           parity_err;
`endif

    int total = 0;
    int bad   = 0;
    int exp_drop = 0;

    ls_xing_rx_if #(.DATA_W(8)) bus ();

    ls_xing_rx #(
        .DATA_W      (8),
        .SYNC_STAGES (2),
        .CNT_W       (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .src_pwr_ok (src_pwr_ok),
`ifdef LS_XING_PARITY_EN
        .ls_parity  (ls_parity),
        .parity_err (parity_err),
`endif
        .busy       (busy),
        .drop_cnt   (drop_cnt),
        .state_dbg  (state_dbg)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time limit reached (got hang, want finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // returns the number of negedges until out_valid is seen, or budget+1
    task automatic wait_valid(input int budget, output int n);
        n = budget + 1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_ack(input logic level, input int budget, output int n);
        n = budget + 1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (bus.ls_ack == level) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic drive_req(input logic [7:0] data);
        bus.ls_data = data;
`ifdef LS_XING_PARITY_EN
        ls_parity = ^data;
`endif
        bus.ls_req = 1'b1;
    endtask

    // source side: accept, wait for ack, drop req, wait for ack release
    task automatic finish_handshake(input string tag);
        int n;
        bus.out_ready = 1'b1;
        wait_ack(1'b1, 10, n);
        check({tag, "_ack_rise"}, 32'(n <= 10), 32'd1);
        bus.out_ready = 1'b0;
        bus.ls_req    = 1'b0;
        wait_ack(1'b0, 10, n);
        check({tag, "_ack_fall"}, 32'(n >= 2 && n <= 3), 32'd1);
        cycles(1);
    endtask

    task automatic do_drop(input logic [7:0] data);
        int n;
        bus.out_ready = 1'b0;
        drive_req(data);
        wait_valid(10, n);
        check("drop_valid_seen", 32'(n), 32'd3);
        src_pwr_ok = 1'b0;
        cycles(4);
        exp_drop = (exp_drop == 3) ? 3 : exp_drop + 1;
        check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        check("drop_ack_low", 32'(bus.ls_ack), 32'd0);
        bus.ls_req = 1'b0;
        src_pwr_ok = 1'b1;
        cycles(4);
        check("drop_back_idle", 32'(state_dbg), 32'(IDLE));
    endtask

    initial begin
        int n;
        int cnt_a;
        int cnt_b;
        rst_n         = 1'b0;
        src_pwr_ok    = 1'b0;
        bus.ls_req    = 1'b0;
        bus.ls_data   = 8'h00;
        bus.out_ready = 1'b0;
`ifdef LS_XING_PARITY_EN
        ls_parity     = 1'b0;
`endif
        cycles(3);
        check("rst_ack", 32'(bus.ls_ack), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(OFF));

        rst_n = 1'b1;
        cycles(2);
        check("off_without_pok", 32'(state_dbg), 32'(OFF));
        src_pwr_ok = 1'b1;
        cycles(4);
        check("powerup_idle", 32'(state_dbg), 32'(IDLE));
        check("idle_busy", 32'(busy), 32'd0);

        // basic transfer
        bus.out_ready = 1'b1;
        drive_req(8'hA5);
        wait_valid(10, n);
        check("basic_latency", 32'(n), 32'd3);
        check("basic_data", 32'(bus.out_data), 32'hA5);
        check("basic_busy", 32'(busy), 32'd1);
        check("basic_ack_not_yet", 32'(bus.ls_ack), 32'd0);
        cycles(1);
        check("basic_ack_rise", 32'(bus.ls_ack), 32'd1);
        check("basic_valid_fall", 32'(bus.out_valid), 32'd0);
        bus.ls_req = 1'b0;
        wait_ack(1'b0, 10, n);
        check("basic_ack_fall", 32'(n >= 2 && n <= 3), 32'd1);
        check("basic_idle", 32'(state_dbg), 32'(IDLE));
        bus.out_ready = 1'b0;
        cycles(1);

        // backpressure
        drive_req(8'h3C);
        wait_valid(10, n);
        check("bp_latency", 32'(n), 32'd3);
        cnt_a = 0;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            if (bus.out_valid === 1'b1 && bus.out_data === 8'h3C && bus.ls_ack === 1'b0) cnt_a++;
        end
        check("bp_hold_cycles", 32'(cnt_a), 32'd10);
        bus.out_ready = 1'b1;
        cycles(1);
        check("bp_ack_rise", 32'(bus.ls_ack), 32'd1);
        check("bp_valid_fall", 32'(bus.out_valid), 32'd0);
        bus.ls_req = 1'b0;
        wait_ack(1'b0, 10, n);
        check("bp_ack_fall", 32'(n >= 2 && n <= 3), 32'd1);
        bus.out_ready = 1'b0;
        cycles(1);

        // power loss in VALID, out_ready stays 0
        drive_req(8'h5A);
        wait_valid(10, n);
        check("pl_latency", 32'(n), 32'd3);
        src_pwr_ok = 1'b0;
        cnt_b = 0;
        n = 11;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.ls_ack !== 1'b0) cnt_b++;
            if (!bus.out_valid) begin
                n = i;
                break;
            end
        end
        check("pl_valid_drop_cycles", 32'(n), 32'd3);
        check("pl_state_off", 32'(state_dbg), 32'(OFF));
        check("pl_ack_stayed_low", 32'(cnt_b), 32'd0);
        exp_drop = 1;
        check("pl_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        check("pl_busy", 32'(busy), 32'd0);

        // power-up with stale request still high (ls_req was never released)
        bus.ls_data = 8'h77;
        src_pwr_ok  = 1'b1;
        cnt_a = 0;
        for (int i = 0; i < 8; i++) begin
            cycles(1);
            if (bus.out_valid !== 1'b0 || state_dbg != OFF) cnt_a++;
        end
        check("stale_ignored", 32'(cnt_a), 32'd0);
        bus.ls_req = 1'b0;
        cycles(4);
        check("stale_release_idle", 32'(state_dbg), 32'(IDLE));
        drive_req(8'h11);
        wait_valid(10, n);
        check("stale_next_latency", 32'(n), 32'd3);
        check("stale_next_data", 32'(bus.out_data), 32'h11);
        finish_handshake("stale");

        // four more drops: counter reaches 3 and holds
        do_drop(8'hE1);
        do_drop(8'hE2);
        do_drop(8'hE3);
        do_drop(8'hE4);
        check("sat_drop_cnt", 32'(drop_cnt), 32'd3);

        // asynchronous reset while VALID
        drive_req(8'hC3);
        wait_valid(10, n);
        check("rstv_valid_seen", 32'(n), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstv_valid", 32'(bus.out_valid), 32'd0);
        check("rstv_data", 32'(bus.out_data), 32'd0);
        check("rstv_ack", 32'(bus.ls_ack), 32'd0);
        check("rstv_busy", 32'(busy), 32'd0);
        check("rstv_drop", 32'(drop_cnt), 32'd0);
        check("rstv_state", 32'(state_dbg), 32'(OFF));
        bus.ls_req = 1'b0;
        cycles(2);
        check("rstv_no_ack_pulse", 32'(bus.ls_ack), 32'd0);
        rst_n = 1'b1;
        cycles(4);
        check("rstv_reup_idle", 32'(state_dbg), 32'(IDLE));
        check("rstv_drop_after", 32'(drop_cnt), 32'd0);

`ifdef LS_XING_PARITY_EN
        // bad parity: word skipped, handshake still completes
        bus.ls_data   = 8'h01;
        ls_parity     = 1'b0;
        bus.ls_req    = 1'b1;
        bus.out_ready = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        n = 11;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (parity_err) cnt_a++;
            if (bus.out_valid) cnt_b++;
            if (bus.ls_ack) begin
                n = i;
                break;
            end
        end
        check("par_ack_latency", 32'(n), 32'd3);
        check("par_valid_never", 32'(cnt_b), 32'd0);
        bus.ls_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (parity_err) cnt_a++;
        end
        check("par_err_pulses", 32'(cnt_a), 32'd1);
        check("par_ack_released", 32'(bus.ls_ack), 32'd0);
`endif

        // a normal word after all of the above
        drive_req(8'h96);
        wait_valid(10, n);
        check("final_latency", 32'(n), 32'd3);
        check("final_data", 32'(bus.out_data), 32'h96);
        finish_handshake("final");
        check("final_idle", 32'(state_dbg), 32'(IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
